mod_int_responder: RTL and testbench
====================================

// Module: mod_int_responder
// PURPOSE
//  CPU-side end of the interrupt handshake: samples int from the interrupt controller and waits for a safe commit point.
//  Then pulses int_ack, saves the return PC (EPC), flushes the pipeline and redirects fetch to the ISR vector.
//  On the return-from-interrupt instruction, redirects fetch back to EPC. Sits between the controller and the CPU fetch/commit stages.
// PARAMETERS
//  VECTOR   32'h00000004  ISR entry address driven on redirect_pc when an interrupt is taken
//  LAT_W    16            width of the saturating interrupt-latency counter
// PORTS
//  clk            in   1      CPU clock; all state updates on posedge
//  rst            in   1      reset, synchronous, active-low
//  int_req        in   1      interrupt pending from the controller (its int output)
//  int_ack        out  1      one-cycle acknowledge to the controller
//  commit_valid   in   1      an instruction completes in the commit stage this cycle
//  commit_pc      in   32     PC of the committing instruction
//  stall          in   1      pipeline stalled this cycle (memory wait etc.)
//  branch_pend    in   1      committing instruction is a branch/jump or has a live delay slot
//  iret           in   1      committing instruction is return-from-interrupt (qualified by commit_valid)
//  epc_we         in   1      software write of EPC (honoured only in ISR state)
//  epc_din        in   32     EPC write data
//  redirect_valid out  1      fetch must load redirect_pc this cycle
//  redirect_pc    out  32     fetch target
//  flush          out  1      kill all younger instructions in flight
//  epc            out  32     saved return address
//  in_isr         out  1      1 while the ISR runs (state ISR or TAKE)
//  lat_cnt        out  LAT_W  cycles from int_req seen to int_ack for the last interrupt
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, int_ack=0, redirect_valid=0, flush=0, redirect_pc=0, epc=0, in_isr=0, lat_cnt=0. Reset wins over everything, mid-handshake included.
//  States: IDLE, WAIT, TAKE, ISR. int_ack, flush and redirect_valid are Moore/registered: high only for the single cycle in TAKE, or the single cycle after an iret in ISR.
//  IDLE: int_req==1 -> WAIT; internal latency counter cleared to 1.
//  WAIT: safe = commit_valid & !stall & !branch_pend.
//   - int_req==0 -> IDLE, no ack, epc unchanged (software masked it).
//   - safe -> TAKE; epc <= commit_pc + 4 (mod 2^32); lat_cnt <= counter.
//   - else stay; counter +1, saturating at 2^LAT_W-1.
//  TAKE (exactly 1 cycle): int_ack=1, flush=1, redirect_valid=1, redirect_pc=VECTOR -> ISR.
//   - int_ack is held for the full clock period, so the controller's negedge sampling sees it exactly once.
//  ISR: int_req ignored (no nesting; the controller clears its global enable on ack).
//   - epc_we -> epc <= epc_din.
//   - commit_valid & iret -> next cycle redirect_valid=1, flush=1, redirect_pc=epc (the value after any same-cycle epc_we) -> IDLE.
//   - iret together with epc_we: the write applies first, and the return uses epc_din.
//  From IDLE after a return, a still-asserted int_req re-enters WAIT on the following cycle; there is no combinational path from int_req to int_ack.
//  iret outside ISR: ignored (no redirect).
//  epc_we outside ISR: ignored.
//  Single-cycle return pulse state: an implicit RET sub-state is permitted; outputs must match the above.
// STRUCTURE
//  Shared package (cpu_int_pkg): state enum {IDLE,WAIT,TAKE,ISR[,RET]}, VECTOR default, EPC_OFFSET=4.
//  One natural sub-module: int_lat_counter (clear/enable/saturate, LAT_W wide). Everything else is a single FSM plus EPC register.
// TESTING
//  1) int_req=1 at t0; stall=0, commit_valid=1, commit_pc=0x100 from t0+1
//     -> TAKE at t0+2, int_ack=1 for 1 cycle, redirect_pc=0x4, epc=0x104, lat_cnt=1.
//  2) int_req=1, stall=1 for 5 cycles, then branch_pend=1 for 2 cycles, then safe with commit_pc=0x200
//     -> no ack while unsafe; ack once, epc=0x204, lat_cnt=8.
//  3) In ISR: epc_we with epc_din=0x300, then iret -> redirect_valid=1, redirect_pc=0x300, flush=1, state IDLE; int_ack stays 0.
//  4) int_req drops during WAIT -> IDLE, int_ack never asserted, epc unchanged; int_req pulses while in ISR -> ignored.
//  5) rst=0 asserted during TAKE and during ISR -> next cycle all outputs at reset values, epc=0.
//     - After release with int_req=1, a normal take occurs.
//  6) iret and epc_we(0x500) in the same cycle -> return to 0x500.
//     - int_req still high afterwards -> WAIT the next cycle, then a second ack.

Source files
------------

// File: rtl/cpu_int_pkg.sv
// Shared types and constants for the CPU-side interrupt responder.
//   int_state_e     : responder FSM states (StRet is the one-cycle return pulse)
//   VECTOR_DEFAULT  : default ISR entry address
//   EPC_OFFSET      : offset from the committing PC to the saved return address
package cpu_int_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StTake,
        StIsr,
        StRet
    } int_state_e;

    localparam logic [31:0] VECTOR_DEFAULT = 32'h0000_0004;
    localparam logic [31:0] EPC_OFFSET     = 32'd4;

endpackage

// File: rtl/int_lat_counter.sv
// Saturating interrupt-latency counter.
//   i_clk  : clock, posedge
//   i_rst  : synchronous active-low reset (count -> 0)
//   i_clr  : load 1 (the cycle the request is first seen counts as one)
//   i_en   : increment, saturating at all-ones
//   o_cnt  : current count
module int_lat_counter
    import cpu_int_pkg::*;
#(
    parameter int unsigned LAT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [LAT_W-1:0] o_cnt
);

    logic [LAT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= LAT_W'(1);
        end else if (i_en && (r_cnt != {LAT_W{1'b1}})) begin
            r_cnt <= r_cnt + LAT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/mod_int_responder.sv
// CPU-side end of the interrupt handshake. Waits for a safe commit point after
// i_int_req, then for one cycle acknowledges, flushes and redirects fetch to
// VECTOR while saving the return PC. On iret inside the ISR, redirects to EPC.
//   i_clk, i_rst          : clock, synchronous active-low reset
//   i_int_req / o_int_ack : handshake with the interrupt controller
//   i_commit_*, i_stall, i_branch_pend, i_iret : commit-stage status
//   i_epc_we, i_epc_din   : software EPC write (ISR only)
//   o_redirect_valid/_pc, o_flush : fetch control (all one-cycle pulses)
//   o_epc, o_in_isr, o_lat_cnt    : status
module mod_int_responder
    import cpu_int_pkg::*;
#(
    parameter logic [31:0] VECTOR = VECTOR_DEFAULT,
    parameter int unsigned LAT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_int_req,
    output logic             o_int_ack,
    input  logic             i_commit_valid,
    input  logic [31:0]      i_commit_pc,
    input  logic             i_stall,
    input  logic             i_branch_pend,
    input  logic             i_iret,
    input  logic             i_epc_we,
    input  logic [31:0]      i_epc_din,
    output logic             o_redirect_valid,
    output logic [31:0]      o_redirect_pc,
    output logic             o_flush,
    output logic [31:0]      o_epc,
    output logic             o_in_isr,
    output logic [LAT_W-1:0] o_lat_cnt
);

    int_state_e       r_state;
    int_state_e       w_state_d;
    logic [31:0]      r_epc;
    logic [LAT_W-1:0] r_lat;
    logic [LAT_W-1:0] w_cnt;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_safe;
    logic             w_take;

    assign w_safe = i_commit_valid & ~i_stall & ~i_branch_pend;
    assign w_take = (r_state == StWait) & i_int_req & w_safe;

    int_lat_counter #(
        .LAT_W (LAT_W)
    ) u_lat_counter (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_cnt (w_cnt)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_clr = 1'b0;
        w_cnt_en  = 1'b0;
        unique case (r_state)
            // StRet is architecturally IDLE with the return pulse on top.
            StIdle, StRet: begin
                w_state_d = StIdle;
                if (i_int_req) begin
                    w_state_d = StWait;
                    w_cnt_clr = 1'b1;
                end
            end
            StWait: begin
                if (!i_int_req) begin
                    w_state_d = StIdle;
                end else if (w_safe) begin
                    w_state_d = StTake;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            StTake: w_state_d = StIsr;
            StIsr: begin
                if (i_commit_valid && i_iret) begin
                    w_state_d = StRet;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // A same-cycle epc write and iret both land here first, so StRet returns
    // to the freshly written value.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_epc <= '0;
            r_lat <= '0;
        end else if (w_take) begin
            r_epc <= i_commit_pc + EPC_OFFSET;
            r_lat <= w_cnt;
        end else if ((r_state == StIsr) && i_epc_we) begin
            r_epc <= i_epc_din;
        end
    end

    // Outputs decode the registered state only: no path from i_int_req.
    always_comb begin
        o_int_ack        = 1'b0;
        o_redirect_valid = 1'b0;
        o_flush          = 1'b0;
        o_redirect_pc    = '0;
        o_in_isr         = 1'b0;
        unique case (r_state)
            StTake: begin
                o_int_ack        = 1'b1;
                o_redirect_valid = 1'b1;
                o_flush          = 1'b1;
                o_redirect_pc    = VECTOR;
                o_in_isr         = 1'b1;
            end
            StRet: begin
                o_redirect_valid = 1'b1;
                o_flush          = 1'b1;
                o_redirect_pc    = r_epc;
            end
            StIsr:   o_in_isr = 1'b1;
            default: ;
        endcase
    end

    assign o_epc     = r_epc;
    assign o_lat_cnt = r_lat;

endmodule

// File: tb/tb_mod_int_responder.sv
module tb_mod_int_responder;

    logic        clk;
    logic        rst;
    logic        int_req;
    logic        int_ack;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        stall;
    logic        branch_pend;
    logic        iret;
    logic        epc_we;
    logic [31:0] epc_din;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] epc;
    logic        in_isr;
    logic [15:0] lat_cnt;

    mod_int_responder u_dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_int_req        (int_req),
        .o_int_ack        (int_ack),
        .i_commit_valid   (commit_valid),
        .i_commit_pc      (commit_pc),
        .i_stall          (stall),
        .i_branch_pend    (branch_pend),
        .i_iret           (iret),
        .i_epc_we         (epc_we),
        .i_epc_din        (epc_din),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc),
        .o_flush          (flush),
        .o_epc            (epc),
        .o_in_isr         (in_isr),
        .o_lat_cnt        (lat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] pc;
        logic [31:0] epc;
        logic [15:0] lat;
        logic        isr;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_ack   = 0;
    int   n_redir = 0;
    int   n_push  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push(input logic a, input logic [31:0] p, input logic [31:0] e,
                        input logic [15:0] l, input logic i);
        exp_t x;
        x.ack = a; x.pc = p; x.epc = e; x.lat = l; x.isr = i;
        exp_q.push_back(x);
        n_push++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ack"},    32'(int_ack),        32'd0);
        chk({tag, " rv"},     32'(redirect_valid), 32'd0);
        chk({tag, " flush"},  32'(flush),          32'd0);
        chk({tag, " rpc"},    redirect_pc,         32'd0);
        chk({tag, " epc"},    epc,                 32'd0);
        chk({tag, " in_isr"}, 32'(in_isr),         32'd0);
        chk({tag, " lat"},    32'(lat_cnt),        32'd0);
    endtask

    // Monitor: every redirect pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (int_ack) n_ack++;
        if (redirect_valid) begin
            n_redir++;
            if (exp_q.size() == 0) begin
                chk("unexpected redirect pc", redirect_pc, 32'hFFFF_FFFF);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("ev ack",    32'(int_ack), 32'(x.ack));
                chk("ev flush",  32'(flush),   32'd1);
                chk("ev rpc",    redirect_pc,  x.pc);
                chk("ev epc",    epc,          x.epc);
                chk("ev lat",    32'(lat_cnt), 32'(x.lat));
                chk("ev in_isr", 32'(in_isr),  32'(x.isr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; int_req = 1'b0; commit_valid = 1'b0; commit_pc = '0;
        stall = 1'b0; branch_pend = 1'b0; iret = 1'b0; epc_we = 1'b0; epc_din = '0;
        tick(); tick();
        chk_reset_outputs("reset");
        rst = 1'b1;

        // 1) immediate safe commit
        int_req = 1'b1; tick();
        commit_valid = 1'b1; commit_pc = 32'h100;
        push(1'b1, 32'h4, 32'h104, 16'd1, 1'b1); tick();
        commit_valid = 1'b0; int_req = 1'b0; tick();
        chk("t1 in_isr", 32'(in_isr), 32'd1);
        chk("t1 acks", 32'(n_ack), 32'd1);

        // 3) epc write then iret
        epc_we = 1'b1; epc_din = 32'h300; tick();
        epc_we = 1'b0;
        chk("t3 epc", epc, 32'h300);
        push(1'b0, 32'h300, 32'h300, 16'd1, 1'b0);
        commit_valid = 1'b1; iret = 1'b1; commit_pc = 32'h180; tick();
        commit_valid = 1'b0; iret = 1'b0; tick();
        chk("t3 acks", 32'(n_ack), 32'd1);

        // 2) stalls then branch then safe
        int_req = 1'b1; tick();
        commit_valid = 1'b1; commit_pc = 32'h200; stall = 1'b1;
        repeat (5) tick();
        stall = 1'b0; branch_pend = 1'b1;
        repeat (2) tick();
        chk("t2 no early ack", 32'(n_ack), 32'd1);
        branch_pend = 1'b0;
        push(1'b1, 32'h4, 32'h204, 16'd8, 1'b1); tick();
        commit_valid = 1'b0; int_req = 1'b0; tick();
        // 4b) int_req pulse inside ISR is ignored
        int_req = 1'b1; tick();
        int_req = 1'b0; tick();
        chk("t4 isr acks", 32'(n_ack), 32'd2);
        chk("t4 isr stays", 32'(in_isr), 32'd1);
        push(1'b0, 32'h204, 32'h204, 16'd8, 1'b0);
        commit_valid = 1'b1; iret = 1'b1; tick();
        commit_valid = 1'b0; iret = 1'b0; tick();

        // 4a) request withdrawn during WAIT
        int_req = 1'b1; tick();
        tick();
        int_req = 1'b0; tick();
        tick();
        chk("t4 masked acks", 32'(n_ack), 32'd2);
        chk("t4 epc kept", epc, 32'h204);
        chk("t4 idle", 32'(in_isr), 32'd0);

        // 5) reset in TAKE, then normal take, then reset in ISR
        int_req = 1'b1; tick();
        commit_valid = 1'b1; commit_pc = 32'h400;
        push(1'b1, 32'h4, 32'h404, 16'd1, 1'b1); tick();
        rst = 1'b0; commit_valid = 1'b0; tick();
        chk_reset_outputs("t5 take rst");
        rst = 1'b1; tick();
        commit_valid = 1'b1; commit_pc = 32'h500;
        push(1'b1, 32'h4, 32'h504, 16'd1, 1'b1); tick();
        commit_valid = 1'b0; int_req = 1'b0; tick();
        chk("t5 in_isr", 32'(in_isr), 32'd1);
        rst = 1'b0; tick();
        chk_reset_outputs("t5 isr rst");
        rst = 1'b1; tick();

        // 6) iret with same-cycle epc write, request still high afterwards
        int_req = 1'b1; tick();
        commit_valid = 1'b1; commit_pc = 32'h600;
        push(1'b1, 32'h4, 32'h604, 16'd1, 1'b1); tick();
        commit_valid = 1'b0; tick();
        push(1'b0, 32'h500, 32'h500, 16'd1, 1'b0);
        commit_valid = 1'b1; iret = 1'b1; epc_we = 1'b1; epc_din = 32'h500; tick();
        iret = 1'b0; epc_we = 1'b0; commit_pc = 32'h700; tick();
        push(1'b1, 32'h4, 32'h704, 16'd1, 1'b1); tick();
        commit_valid = 1'b0; int_req = 1'b0; tick();
        tick();

        chk("total acks", 32'(n_ack), 32'd6);
        chk("redirects seen", 32'(n_redir), 32'(n_push));
        chk("queue drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
